// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative multiply/divide/remainder.
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; op/a/b captured on accept
//   op, a, b            4-bit opcode and WIDTH-bit operands
//   out_valid/out_ready result handshake; res/szcv held until transfer
//   res, szcv           registered result and {S,Z,C,V} flags
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       szcv
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;     // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opr_q, opr_d;   // multiplicand / divisor
  logic             bz_q, bz_d;     // divisor was zero
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       szcv_q, szcv_d;
  logic             out_valid_q, out_valid_d;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign szcv      = szcv_q;

  // Single-cycle datapath, evaluated on the live inputs at accept.
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_w, sub_w, sll_w, srl_w;
  logic signed [WIDTH:0] sra_w;
  logic [SHW:0]       rol_rsh;
  logic [WIDTH-1:0]   rol_w;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v;

  always_comb begin
    shamt   = b[SHW-1:0];
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    // Extra guard bit on each shifter catches the last bit shifted out as C;
    // a zero shift leaves the guard bit at 0.
    sll_w   = {1'b0, a} << shamt;
    srl_w   = {a, 1'b0} >> shamt;
    sra_w   = $signed({a, 1'b0}) >>> shamt;
    rol_rsh = CNT_LOAD - {1'b0, shamt};
    rol_w   = (shamt == '0) ? a : ((a << shamt) | (a >> rol_rsh));

    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_MOV: sc_res = b;
      OP_SLL: begin
        sc_res = sll_w[WIDTH-1:0];
        sc_c   = sll_w[WIDTH];
      end
      OP_ROL: sc_res = rol_w;
      OP_SRL: begin
        sc_res = srl_w[WIDTH:1];
        sc_c   = srl_w[0];
      end
      OP_SRA: begin
        sc_res = sra_w[WIDTH:1];
        sc_c   = sra_w[0];
      end
      default: sc_res = '0;
    endcase
  end

  // One iteration step for shift-add multiply and restoring divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] rem_n, quo_n;

  always_comb begin
    mul_sum = sh_q[0] ? ({1'b0, acc_q} + {1'b0, opr_q}) : {1'b0, acc_q};
    {mul_hi_n, mul_lo_n} = {mul_sum, sh_q[WIDTH-1:1]};

    // Two guard bits so a zero divisor never looks like a borrow; the
    // quotient then fills with ones and the remainder collects a.
    div_sh   = {acc_q, sh_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opr_q};
    if (!div_diff[WIDTH+1]) begin
      rem_n = div_diff[WIDTH-1:0];
      quo_n = {sh_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = div_sh[WIDTH-1:0];
      quo_n = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  logic [WIDTH-1:0] it_res;
  logic             it_c, it_v;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    sh_d        = sh_q;
    opr_d       = opr_q;
    bz_d        = bz_q;
    res_d       = res_q;
    szcv_d      = szcv_q;
    out_valid_d = out_valid_q;
    it_res      = '0;
    it_c        = 1'b0;
    it_v        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (op == OP_MULU || op == OP_DIVU || op == OP_REMU) begin
            state_d = S_ITER;
            cnt_d   = CNT_LOAD;
            bz_d    = (b == '0);
            acc_d   = '0;
            if (op == OP_MULU) begin
              sh_d  = b;
              opr_d = a;
            end else begin
              sh_d  = a;
              opr_d = b;
            end
          end else begin
            state_d     = S_DONE;
            res_d       = sc_res;
            szcv_d      = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
            out_valid_d = 1'b1;
          end
        end
      end

      S_ITER: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MULU) begin
          acc_d  = mul_hi_n;
          sh_d   = mul_lo_n;
          it_res = mul_lo_n;
          it_c   = |mul_hi_n;
        end else begin
          acc_d  = rem_n;
          sh_d   = quo_n;
          it_res = (op_q == OP_DIVU) ? quo_n : rem_n;
          it_v   = bz_q;
        end
        if (cnt_q == CNT_ONE) begin
          state_d     = S_DONE;
          res_d       = it_res;
          szcv_d      = {it_res[WIDTH-1], (it_res == '0), it_c, it_v};
          out_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      opr_q       <= '0;
      bz_q        <= 1'b0;
      res_q       <= '0;
      szcv_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      sh_q        <= sh_d;
      opr_q       <= opr_d;
      bz_q        <= bz_d;
      res_q       <= res_d;
      szcv_q      <= szcv_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an
// arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [3:0]   szcv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .szcv      (szcv)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {res, S, Z, C, V}.
  function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    int unsigned ua, ub, r, n;
    int          sa;
    longint      p;
    bit          c, v;
    ua = x; ub = y; n = y & 15; r = 0; c = 0; v = 0;
    case (o)
      4'h0: begin
        r = (ua + ub) & 'hFFFF;
        c = (ua + ub) > 'hFFFF;
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      4'h1, 4'h5: begin
        r = (ua - ub) & 'hFFFF;
        c = ua < ub;
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h6: r = ub;
      4'h8: begin
        r = (ua << n) & 'hFFFF;
        c = (n != 0) && (((ua >> (16 - n)) & 1) != 0);
      end
      4'h9: r = ((ua << n) | (ua >> (16 - n))) & 'hFFFF;
      4'hA: begin
        r = ua >> n;
        c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
      end
      4'hB: begin
        sa = x[15] ? int'(ua) - 65536 : int'(ua);
        r  = (sa >>> n) & 'hFFFF;
        c  = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
      end
      4'hC: begin
        p = longint'(ua) * longint'(ub);
        r = int'(p & 'hFFFF);
        c = (p >> 16) != 0;
      end
      4'hD: begin
        r = (ub == 0) ? 'hFFFF : ua / ub;
        v = (ub == 0);
      end
      4'hE: begin
        r = (ub == 0) ? ua : ua % ub;
        v = (ub == 0);
      end
      default: r = 0;
    endcase
    return {r[15:0], r[15], (r[15:0] == 16'h0), c, v};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after transfer.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                        input logic [15:0] y, input bit hold);
    logic [19:0] e;
    logic [15:0] r0;
    logic [3:0]  f0;
    int edges, exp_lat, busy_rdy;
    e = model(o, x, y);
    exp_lat = (o == 4'hC || o == 4'hD || o == 4'hE) ? W + 1 : 1;
    chk($sformatf("%s in_ready idle", tag), in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    edges = 1;
    busy_rdy = 0;
    while (!out_valid && edges < 40) begin
      if (in_ready) busy_rdy++;
      @(negedge clk);
      edges++;
    end
    chk($sformatf("%s latency", tag), edges, exp_lat);
    chk($sformatf("%s in_ready busy", tag), busy_rdy + int'(in_ready), 0);
    chk($sformatf("%s res", tag), res, e[19:4]);
    chk($sformatf("%s szcv", tag), szcv, e[3:0]);
    if (hold) begin
      r0 = res; f0 = szcv;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk($sformatf("%s hold valid", tag), out_valid, 1);
        chk($sformatf("%s hold res", tag), res, r0);
        chk($sformatf("%s hold szcv", tag), szcv, f0);
        chk($sformatf("%s hold in_ready", tag), in_ready, 0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s out_valid drop", tag), out_valid, 0);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("reset res", res, 0);
    chk("reset szcv", szcv, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("ADD ovf",   4'h0, 16'h7FFF, 16'h0001, 1'b0);
    run_op("SUB borrow",4'h1, 16'h0001, 16'h0002, 1'b0);
    run_op("CMP borrow",4'h5, 16'h0001, 16'h0002, 1'b0);
    run_op("SRA 1",     4'hB, 16'h8001, 16'h0001, 1'b0);
    run_op("SRA 3",     4'hB, 16'h8000, 16'h0003, 1'b0);
    run_op("SRA 15",    4'hB, 16'h8000, 16'h000F, 1'b0);
    run_op("SLL 1",     4'h8, 16'h8001, 16'h0001, 1'b0);
    run_op("SLL 0",     4'h8, 16'h8001, 16'h0000, 1'b0);
    run_op("SRL 0",     4'hA, 16'h8001, 16'h0010, 1'b0);
    run_op("ROL 4",     4'h9, 16'h8001, 16'h0004, 1'b0);
    run_op("MULU wrap", 4'hC, 16'h0100, 16'h0100, 1'b0);
    run_op("MULU small",4'hC, 16'h0012, 16'h0034, 1'b0);
    run_op("MULU max",  4'hC, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("DIVU",      4'hD, 16'h0064, 16'h0007, 1'b0);
    run_op("REMU",      4'hE, 16'h0064, 16'h0007, 1'b0);
    run_op("DIVU by0",  4'hD, 16'h1234, 16'h0000, 1'b0);
    run_op("REMU by0",  4'hE, 16'h1234, 16'h0000, 1'b0);
    run_op("DIVU big",  4'hD, 16'hFFFF, 16'h8001, 1'b0);
    run_op("UNK 7",     4'h7, 16'h1234, 16'h5678, 1'b0);
    run_op("XOR hold",  4'h4, 16'hA5A5, 16'h0FF0, 1'b1);
    run_op("DIVU hold", 4'hD, 16'hBEEF, 16'h0013, 1'b1);

    // Abort a multiply in flight.
    in_valid = 1'b1; op = 4'hC; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort busy", in_ready, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort no result", out_valid, 0);
    end
    chk("abort in_ready after", in_ready, 1);
    run_op("ADD after reset", 4'h0, 16'h0002, 16'h0003, 1'b0);

    for (int i = 0; i < 250; i++) begin
      ro = 4'($urandom);
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'($urandom_range(1, 20));
        default: rb = 16'($urandom);
      endcase
      run_op($sformatf("rand%0d op%0h", i, ro), ro, ra, rb, ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
